// File: rtl/ls_ctrl.sv
// Load/store controller: accepts one op from the LSB, runs it against the memory
// controller, extends load data and broadcasts completion on the LS CDB.
module ls_ctrl #(
    parameter int         OP_WIDTH   = 6,
    parameter int         ROB_WIDTH  = 4,
    parameter logic [1:0] IO_BASE_HI = 2'b11
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 rdy_lsb_in,
    input  logic [OP_WIDTH-1:0]  opcode_lsb_in,
    input  logic [31:0]          vj_lsb_in,
    input  logic [31:0]          vk_lsb_in,
    input  logic [31:0]          imm_lsb_in,
    input  logic [ROB_WIDTH:0]   rob_id_lsb_in,
    output logic                 idle_lsb_out,
    input  logic [ROB_WIDTH-1:0] head_id_rob_in,
    output logic                 mem_req_out,
    output logic                 mem_we_out,
    output logic [31:0]          mem_addr_out,
    output logic [2:0]           mem_size_out,
    output logic [31:0]          mem_wdata_out,
    input  logic                 mem_done_in,
    input  logic [31:0]          mem_rdata_in,
    output logic                 rdy_cdb_out,
    output logic [31:0]          result_cdb_out,
    output logic [ROB_WIDTH:0]   rob_id_cdb_out,
    input  logic                 refresh_rob_cdb_in
);

    localparam logic [OP_WIDTH-1:0] OP_LB  = OP_WIDTH'(0);
    localparam logic [OP_WIDTH-1:0] OP_LH  = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_LW  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_LBU = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_LHU = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_SB  = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_SH  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SW  = OP_WIDTH'(7);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_HEAD,
        WAIT_MEM,
        DRAIN
    } state_e;

    state_e               state_q;
    logic [OP_WIDTH-1:0]  op_q;
    logic [ROB_WIDTH:0]   rob_id_q;
    logic                 mem_req_q;
    logic                 mem_we_q;
    logic [31:0]          mem_addr_q;
    logic [2:0]           mem_size_q;
    logic [31:0]          mem_wdata_q;
    logic                 rdy_cdb_q;
    logic [31:0]          result_q;
    logic [ROB_WIDTH:0]   rob_id_cdb_q;

    logic [31:0]          addr_d;
    logic [2:0]           size_d;
    logic                 is_store_d;
    logic                 is_io_d;
    logic [31:0]          load_data_d;

    // Decode of the incoming op; I/O loads must wait until they reach the ROB head.
    always_comb begin
        addr_d     = vj_lsb_in + imm_lsb_in;
        size_d     = 3'd4;
        is_store_d = 1'b0;
        case (opcode_lsb_in)
            OP_LB, OP_LBU: size_d = 3'd1;
            OP_LH, OP_LHU: size_d = 3'd2;
            OP_SB: begin
                size_d     = 3'd1;
                is_store_d = 1'b1;
            end
            OP_SH: begin
                size_d     = 3'd2;
                is_store_d = 1'b1;
            end
            OP_SW: is_store_d = 1'b1;
            default: size_d = 3'd4;
        endcase
        is_io_d = !is_store_d && (addr_d[17:16] == IO_BASE_HI);
    end

    always_comb begin
        load_data_d = mem_rdata_in;
        case (op_q)
            OP_LB:   load_data_d = {{24{mem_rdata_in[7]}}, mem_rdata_in[7:0]};
            OP_LH:   load_data_d = {{16{mem_rdata_in[15]}}, mem_rdata_in[15:0]};
            OP_LBU:  load_data_d = {24'd0, mem_rdata_in[7:0]};
            OP_LHU:  load_data_d = {16'd0, mem_rdata_in[15:0]};
            OP_LW:   load_data_d = mem_rdata_in;
            default: load_data_d = mem_rdata_in;
        endcase
    end

    // The memory controller cannot abort, so a flushed access drains before IDLE.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q      <= IDLE;
            op_q         <= '0;
            rob_id_q     <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_size_q   <= '0;
            mem_wdata_q  <= '0;
            rdy_cdb_q    <= 1'b0;
            result_q     <= '0;
            rob_id_cdb_q <= '0;
        end else if (rdy_in) begin
            rdy_cdb_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rdy_lsb_in && !refresh_rob_cdb_in) begin
                        op_q        <= opcode_lsb_in;
                        rob_id_q    <= rob_id_lsb_in;
                        mem_addr_q  <= addr_d;
                        mem_size_q  <= size_d;
                        mem_we_q    <= is_store_d;
                        mem_wdata_q <= vk_lsb_in;
                        if (is_io_d) begin
                            state_q <= WAIT_HEAD;
                        end else begin
                            state_q   <= WAIT_MEM;
                            mem_req_q <= 1'b1;
                        end
                    end
                end
                WAIT_HEAD: begin
                    if (refresh_rob_cdb_in) begin
                        state_q <= IDLE;
                    end else if (rob_id_q[ROB_WIDTH-1:0] == head_id_rob_in) begin
                        state_q   <= WAIT_MEM;
                        mem_req_q <= 1'b1;
                    end
                end
                WAIT_MEM: begin
                    if (mem_done_in) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                        if (!refresh_rob_cdb_in) begin
                            rdy_cdb_q    <= 1'b1;
                            result_q     <= mem_we_q ? 32'd0 : load_data_d;
                            rob_id_cdb_q <= rob_id_q;
                        end
                    end else if (refresh_rob_cdb_in) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (mem_done_in) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_lsb_out   = (state_q == IDLE);
    assign mem_req_out    = mem_req_q;
    assign mem_we_out     = mem_we_q;
    assign mem_addr_out   = mem_addr_q;
    assign mem_size_out   = mem_size_q;
    assign mem_wdata_out  = mem_wdata_q;
    assign rdy_cdb_out    = rdy_cdb_q;
    assign result_cdb_out = result_q;
    assign rob_id_cdb_out = rob_id_cdb_q;

endmodule

// File: tb/tb_ls_ctrl.sv
// Self-checking bench for ls_ctrl: directed ops, a transaction-level model of the
// expected bus/CDB behaviour and a per-cycle compare process.
module tb_ls_ctrl;

    localparam int OP_WIDTH  = 6;
    localparam int ROB_WIDTH = 4;

    localparam logic [5:0] LB  = 6'd0;
    localparam logic [5:0] LH  = 6'd1;
    localparam logic [5:0] LW  = 6'd2;
    localparam logic [5:0] LBU = 6'd3;
    localparam logic [5:0] LHU = 6'd4;
    localparam logic [5:0] SB  = 6'd5;
    localparam logic [5:0] SH  = 6'd6;
    localparam logic [5:0] SW  = 6'd7;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b0;
    logic        rdy_in = 1'b1;
    logic        rdy_lsb_in = 1'b0;
    logic [5:0]  opcode_lsb_in = '0;
    logic [31:0] vj_lsb_in = '0;
    logic [31:0] vk_lsb_in = '0;
    logic [31:0] imm_lsb_in = '0;
    logic [4:0]  rob_id_lsb_in = '0;
    logic        idle_lsb_out;
    logic [3:0]  head_id_rob_in = '0;
    logic        mem_req_out;
    logic        mem_we_out;
    logic [31:0] mem_addr_out;
    logic [2:0]  mem_size_out;
    logic [31:0] mem_wdata_out;
    logic        mem_done_in = 1'b0;
    logic [31:0] mem_rdata_in = '0;
    logic        rdy_cdb_out;
    logic [31:0] result_cdb_out;
    logic [4:0]  rob_id_cdb_out;
    logic        refresh_rob_cdb_in = 1'b0;

    ls_ctrl #(
        .OP_WIDTH  (OP_WIDTH),
        .ROB_WIDTH (ROB_WIDTH),
        .IO_BASE_HI(2'b11)
    ) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rdy_in            (rdy_in),
        .rdy_lsb_in        (rdy_lsb_in),
        .opcode_lsb_in     (opcode_lsb_in),
        .vj_lsb_in         (vj_lsb_in),
        .vk_lsb_in         (vk_lsb_in),
        .imm_lsb_in        (imm_lsb_in),
        .rob_id_lsb_in     (rob_id_lsb_in),
        .idle_lsb_out      (idle_lsb_out),
        .head_id_rob_in    (head_id_rob_in),
        .mem_req_out       (mem_req_out),
        .mem_we_out        (mem_we_out),
        .mem_addr_out      (mem_addr_out),
        .mem_size_out      (mem_size_out),
        .mem_wdata_out     (mem_wdata_out),
        .mem_done_in       (mem_done_in),
        .mem_rdata_in      (mem_rdata_in),
        .rdy_cdb_out       (rdy_cdb_out),
        .result_cdb_out    (result_cdb_out),
        .rob_id_cdb_out    (rob_id_cdb_out),
        .refresh_rob_cdb_in(refresh_rob_cdb_in)
    );

    always #5 clk_in = ~clk_in;

    int nVec  = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    logic        expIdle = 1'b1;
    logic        expReq = 1'b0;
    logic        expWe = 1'b0;
    logic        expCdb = 1'b0;
    logic [31:0] expAddr = '0;
    logic [2:0]  expSize = '0;
    logic [31:0] expWdata = '0;
    logic [31:0] expResult = '0;
    logic [4:0]  expRob = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Model: what the architecture says an op must produce.
    function automatic logic [31:0] mAddr(input logic [31:0] vj, input logic [31:0] imm);
        return vj + imm;
    endfunction

    function automatic bit mStore(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [2:0] mSize(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 3'd1;
        if (op == LH || op == LHU || op == SH) return 3'd2;
        return 3'd4;
    endfunction

    function automatic bit mIo(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] imm);
        longint a;
        a = longint'(mAddr(vj, imm));
        return !mStore(op) && (((a / 65536) % 4) == 3);
    endfunction

    function automatic logic [31:0] mResult(input logic [5:0] op, input logic [31:0] rdata);
        longint v;
        if (mStore(op)) return 32'd0;
        case (op)
            LB: begin
                v = longint'(rdata) % 256;
                if (v >= 128) v = v - 256;
            end
            LH: begin
                v = longint'(rdata) % 65536;
                if (v >= 32768) v = v - 65536;
            end
            LBU:     v = longint'(rdata) % 256;
            LHU:     v = longint'(rdata) % 65536;
            default: v = longint'(rdata);
        endcase
        return 32'(v);
    endfunction

    always @(negedge clk_in) begin
        if (checkEn) begin
            chk("idle", {31'd0, idle_lsb_out}, {31'd0, expIdle});
            chk("mem_req", {31'd0, mem_req_out}, {31'd0, expReq});
            if (expReq) begin
                chk("mem_addr", mem_addr_out, expAddr);
                chk("mem_size", {29'd0, mem_size_out}, {29'd0, expSize});
                chk("mem_we", {31'd0, mem_we_out}, {31'd0, expWe});
                if (expWe) chk("mem_wdata", mem_wdata_out, expWdata);
            end
            chk("rdy_cdb", {31'd0, rdy_cdb_out}, {31'd0, expCdb});
            if (expCdb) begin
                chk("cdb_result", result_cdb_out, expResult);
                chk("cdb_rob", {27'd0, rob_id_cdb_out}, {27'd0, expRob});
            end
        end
    end

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    // Runs one op starting in an IDLE cycle; returns in the cycle after done.
    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                                 input logic [31:0] imm, input logic [4:0] rob, input logic [31:0] rdata,
                                 input int lat, input int headWait, input int flushAt, input int freezeAt,
                                 input logic [31:0] litAddr, input logic [31:0] litResult);
        rdy_lsb_in    = 1'b1;
        opcode_lsb_in = op;
        vj_lsb_in     = vj;
        vk_lsb_in     = vk;
        imm_lsb_in    = imm;
        rob_id_lsb_in = rob;
        tick;
        rdy_lsb_in    = 1'b0;
        opcode_lsb_in = LW;
        vj_lsb_in     = 32'hA5A5_A5A5;
        vk_lsb_in     = 32'h5A5A_5A5A;
        imm_lsb_in    = 32'h0F0F_0F0F;
        rob_id_lsb_in = 5'h1F;
        expIdle   = 1'b0;
        expCdb    = 1'b0;
        expAddr   = mAddr(vj, imm);
        expSize   = mSize(op);
        expWe     = mStore(op);
        expWdata  = vk;
        expRob    = rob;
        expResult = mResult(op, rdata);
        if (mIo(op, vj, imm)) begin
            expReq = 1'b0;
            head_id_rob_in = rob[3:0] ^ 4'h6;
            for (int j = 0; j < headWait; j++) tick;
            head_id_rob_in = rob[3:0];
            tick;
        end
        expReq = 1'b1;
        chk("lit_addr", mem_addr_out, litAddr);
        for (int i = 1; i <= lat; i++) begin
            if (i == freezeAt) begin
                rdy_in = 1'b0;
                repeat (4) tick;
                rdy_in = 1'b1;
            end
            if (i == flushAt) refresh_rob_cdb_in = 1'b1;
            if (i == lat) begin
                mem_done_in  = 1'b1;
                mem_rdata_in = rdata;
            end
            tick;
            refresh_rob_cdb_in = 1'b0;
            mem_done_in  = 1'b0;
            mem_rdata_in = '0;
        end
        expReq  = 1'b0;
        expIdle = 1'b1;
        expCdb  = (flushAt == 0);
        if (flushAt == 0) chk("lit_result", result_cdb_out, litResult);
    endtask

    task automatic checkOutput;
        tick;
        expCdb = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_idle", {31'd0, idle_lsb_out}, 32'd1);
        chk("rst_req", {31'd0, mem_req_out}, 32'd0);
        chk("rst_we", {31'd0, mem_we_out}, 32'd0);
        chk("rst_addr", mem_addr_out, 32'd0);
        chk("rst_size", {29'd0, mem_size_out}, 32'd0);
        chk("rst_wdata", mem_wdata_out, 32'd0);
        chk("rst_cdb", {31'd0, rdy_cdb_out}, 32'd0);
        chk("rst_result", result_cdb_out, 32'd0);
        chk("rst_rob", {27'd0, rob_id_cdb_out}, 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1;
        tick;
        checkEn = 1'b1;

        // LW then back-to-back sub-word loads accepted in the broadcast cycle.
        applyStimulus(LW, 32'h1000, 32'h0, 32'd4, 5'd2, 32'hDEADBEEF, 3, 0, 0, 0, 32'h1004, 32'hDEADBEEF);
        applyStimulus(LB, 32'h100, 32'h0, 32'd0, 5'd3, 32'h80, 2, 0, 0, 0, 32'h100, 32'hFFFFFF80);
        applyStimulus(LBU, 32'h101, 32'h0, 32'd0, 5'd4, 32'h80, 1, 0, 0, 0, 32'h101, 32'h00000080);
        applyStimulus(LH, 32'h200, 32'h0, 32'd2, 5'd6, 32'h8001, 2, 0, 0, 0, 32'h202, 32'hFFFF8001);
        applyStimulus(LHU, 32'h200, 32'h0, 32'd6, 5'd7, 32'h8001, 1, 0, 0, 0, 32'h206, 32'h00008001);
        checkOutput;

        applyStimulus(SH, 32'h2000, 32'h12345678, 32'hFFFFFFFE, 5'd8, 32'h0, 2, 0, 0, 0, 32'h1FFE, 32'h0);
        checkOutput;
        applyStimulus(SB, 32'h1000, 32'h000000AB, 32'd3, 5'd9, 32'h0, 1, 0, 0, 0, 32'h1003, 32'h0);
        checkOutput;

        // I/O-region load waits for the ROB head; an I/O-region store does not.
        applyStimulus(LW, 32'h30000, 32'h0, 32'd0, 5'd5, 32'h1234, 2, 3, 0, 0, 32'h30000, 32'h1234);
        checkOutput;
        applyStimulus(SW, 32'h30000, 32'h77, 32'h10, 5'd9, 32'h0, 1, 0, 0, 0, 32'h30010, 32'h0);
        checkOutput;

        // Flush mid-access, then flush coinciding with done.
        applyStimulus(LW, 32'h3000, 32'h0, 32'd8, 5'd10, 32'h11112222, 4, 0, 2, 0, 32'h3008, 32'h0);
        checkOutput;
        applyStimulus(LB, 32'h3000, 32'h0, 32'd9, 5'd11, 32'hFF, 2, 0, 2, 0, 32'h3009, 32'h0);
        checkOutput;

        // Flush in IDLE drops the offered op.
        rdy_lsb_in = 1'b1;
        opcode_lsb_in = LW;
        refresh_rob_cdb_in = 1'b1;
        tick;
        rdy_lsb_in = 1'b0;
        refresh_rob_cdb_in = 1'b0;
        tick;

        // Flush in WAIT_HEAD beats a matching head.
        rdy_lsb_in = 1'b1;
        opcode_lsb_in = LW;
        vj_lsb_in = 32'h3_0040;
        imm_lsb_in = 32'd0;
        rob_id_lsb_in = 5'd12;
        tick;
        rdy_lsb_in = 1'b0;
        expIdle = 1'b0;
        head_id_rob_in = 4'd12;
        refresh_rob_cdb_in = 1'b1;
        tick;
        refresh_rob_cdb_in = 1'b0;
        expIdle = 1'b1;
        tick;
        tick;

        // Enable held low for 4 cycles in the middle of a store.
        applyStimulus(SW, 32'h40, 32'hCAFEF00D, 32'h10, 5'd13, 32'h0, 3, 0, 0, 2, 32'h50, 32'h0);
        checkOutput;

        // Asynchronous reset while the memory access is outstanding.
        rdy_lsb_in = 1'b1;
        opcode_lsb_in = LW;
        vj_lsb_in = 32'h500;
        imm_lsb_in = 32'd0;
        rob_id_lsb_in = 5'd14;
        tick;
        rdy_lsb_in = 1'b0;
        expIdle = 1'b0;
        expReq = 1'b1;
        expAddr = 32'h500;
        expSize = 3'd4;
        expWe = 1'b0;
        tick;
        #2;
        rst_in = 1'b0;
        expReq = 1'b0;
        expIdle = 1'b1;
        #1;
        chk("async_rst_req", {31'd0, mem_req_out}, 32'd0);
        chk("async_rst_idle", {31'd0, idle_lsb_out}, 32'd1);
        @(negedge clk_in);
        #1;
        rst_in = 1'b1;
        tick;
        applyStimulus(LH, 32'h600, 32'h0, 32'd0, 5'd15, 32'h7FFF, 1, 0, 0, 0, 32'h600, 32'h00007FFF);
        checkOutput;
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
